// File: rtl/kmap_gray_tester.sv
// Walks a 4-input function under test through all 16 inputs in Gray-code order
// and checks its response against a truth table, once per cycle in a hold window.
module kmap_gray_tester #(
  parameter logic [15:0] EXPECT = 16'h7EE8,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned HOLD   = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  output logic [3:0] dut_i,
  input  logic       dut_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       err_valid,
  output logic [3:0] first_err_idx
);

  localparam int unsigned CW = 4;
  localparam int unsigned EW = 5;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
  localparam logic [EW-1:0] ERR_MAX     = EW'(16);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vfail_q, vfail_d;
  logic [3:0]    dut_i_q, dut_i_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [EW-1:0] err_count_q, err_count_d;
  logic          err_valid_q, err_valid_d;
  logic [3:0]    first_q, first_d;
  logic          mismatch;
  logic          vec_bad;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      vfail_q     <= 1'b0;
      dut_i_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      vfail_q     <= vfail_d;
      dut_i_q     <= dut_i_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      first_q     <= first_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    vfail_d     = vfail_q;
    dut_i_d     = dut_i_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    first_d     = first_q;
    mismatch    = (dut_o != EXPECT[dut_i_q]);
    vec_bad     = vfail_q | mismatch;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d      = '0;
          dut_i_d     = '0;
          cnt_d       = '0;
          vfail_d     = 1'b0;
          err_count_d = '0;
          err_valid_d = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        vfail_d = vec_bad;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          vfail_d = 1'b0;
          if (vec_bad) begin
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + EW'(1);
            end
            if (!err_valid_q) begin
              first_d     = dut_i_q;
              err_valid_d = 1'b1;
            end
          end
          if (step_q != 4'd15) begin
            step_d  = step_q + 4'd1;
            dut_i_d = step_d ^ (step_d >> 1);
            state_d = ST_SETTLE;
          end else begin
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dut_i         = dut_i_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_q;

endmodule
